// File: rtl/multi_project_pkg.sv
// Shared types and constants for the multi-project pad multiplexer.
package multi_project_pkg;

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_RUN    = 2'd1,
      ST_SWITCH = 2'd2
   } mux_state_e;

   localparam int RESET_CYCLES_MIN = 1;

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop synchroniser for the pad input bank, cleared on reset.
module gpio_in_sync #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/multi_project_mux.sv
// Selects one of NUM_PROJECTS designs onto a shared pad bank via a sequenced reset FSM.
// Optional input synchroniser enabled by defining MPH_SYNC_IN_EN.
module multi_project_mux
   import multi_project_pkg::*;
#(
   parameter int NUM_PROJECTS = 4,
   parameter int GPIO_WIDTH   = 10,
   parameter int RESET_CYCLES = 8,
   parameter int ID_W         = $clog2(NUM_PROJECTS + 1)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             sel_valid,
   output logic                             sel_ready,
   input  logic [ID_W-1:0]                  sel_id,
   output logic [ID_W-1:0]                  active_id,
   output logic                             switching,
   input  logic [GPIO_WIDTH-1:0]            gpio_in,
   output logic [GPIO_WIDTH-1:0]            gpio_out,
   output logic [GPIO_WIDTH-1:0]            gpio_oe,
   output logic [NUM_PROJECTS-1:0]          proj_reset_n,
   output logic [NUM_PROJECTS*GPIO_WIDTH-1:0] proj_gpio_in,
   input  logic [NUM_PROJECTS*GPIO_WIDTH-1:0] proj_gpio_out
);

   localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [ID_W-1:0] ID_NONE = ID_W'(NUM_PROJECTS);

   mux_state_e              state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [ID_W-1:0]         id_q;
   logic [ID_W-1:0]         id_d;
   logic [ID_W-1:0]         active_id_q;
   logic [NUM_PROJECTS-1:0] proj_reset_n_q;
   logic [GPIO_WIDTH-1:0]   gpio_oe_q;
   logic                    switching_q;
   logic                    sel_ready_q;
   logic [GPIO_WIDTH-1:0]   gpio_in_s;

   // Out-of-range requests collapse onto the single "none" encoding.
   assign id_d = (sel_id >= ID_NONE) ? ID_NONE : sel_id;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_OFF;
         cnt_q          <= '0;
         id_q           <= ID_NONE;
         active_id_q    <= ID_NONE;
         proj_reset_n_q <= '0;
         gpio_oe_q      <= '0;
         switching_q    <= 1'b0;
         sel_ready_q    <= 1'b1;
      end else begin
         case (state_q)
            ST_OFF, ST_RUN: begin
               if (sel_valid && sel_ready_q) begin
                  state_q        <= ST_SWITCH;
                  cnt_q          <= CNT_W'(RESET_CYCLES - 1);
                  id_q           <= id_d;
                  active_id_q    <= ID_NONE;
                  proj_reset_n_q <= '0;
                  gpio_oe_q      <= '0;
                  switching_q    <= 1'b1;
                  sel_ready_q    <= 1'b0;
               end
            end
            ST_SWITCH: begin
               if (cnt_q == '0) begin
                  switching_q <= 1'b0;
                  sel_ready_q <= 1'b1;
                  if (id_q < ID_NONE) begin
                     state_q        <= ST_RUN;
                     active_id_q    <= id_q;
                     proj_reset_n_q <= NUM_PROJECTS'(1) << id_q;
                     gpio_oe_q      <= '1;
                  end else begin
                     state_q <= ST_OFF;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q        <= ST_OFF;
               active_id_q    <= ID_NONE;
               proj_reset_n_q <= '0;
               gpio_oe_q      <= '0;
               switching_q    <= 1'b0;
               sel_ready_q    <= 1'b1;
            end
         endcase
      end
   end

`ifdef MPH_SYNC_IN_EN
   gpio_in_sync #(
      .WIDTH (GPIO_WIDTH)
   ) u_gpio_in_sync (
      .clk   (clk),
      .rst_n (reset),
      .d_i   (gpio_in),
      .q_o   (gpio_in_s)
   );
`else
   assign gpio_in_s = gpio_in;
`endif

   // active_id_q holds ID_NONE outside RUN, so no separate state qualifier is needed.
   always_comb begin
      gpio_out = '0;
      for (int k = 0; k < NUM_PROJECTS; k++) begin
         if (active_id_q == ID_W'(k)) begin
            gpio_out = proj_gpio_out[k*GPIO_WIDTH +: GPIO_WIDTH];
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_PROJECTS; gi++) begin : g_proj_in
         assign proj_gpio_in[gi*GPIO_WIDTH +: GPIO_WIDTH] =
            (active_id_q == ID_W'(gi)) ? gpio_in_s : '0;
      end
   endgenerate

   assign sel_ready    = sel_ready_q;
   assign switching    = switching_q;
   assign active_id    = active_id_q;
   assign proj_reset_n = proj_reset_n_q;
   assign gpio_oe      = gpio_oe_q;

endmodule
